// File: rtl/chamber_timer.sv
// Countdown timer serving the bathysphere interlock: one fill/drain/wait interval at a time, 1-cycle *Finished pulse at expiry.
// Optional CHAMBER_TIMER_HEX_EN adds registered active-low 7-segment tens/ones of secLeft.
module chamber_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int FILL_SEC  = 10,
  parameter int DRAIN_SEC = 10,
  parameter int WAIT_SEC  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       filling,
  input  logic       draining,
  input  logic       waiting,
  output logic       fillFinished,
  output logic       drainFinished,
  output logic       waitFinished,
  output logic [7:0] secLeft,
  output logic [1:0] mode,
  output logic       busy
`ifdef CHAMBER_TIMER_HEX_EN
  ,
  output logic [6:0] hexTens,
  output logic [6:0] hexOnes
`endif
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TICK_MAX = PW'(CLK_HZ - 1);

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_DRAIN = 2'd2;
  localparam logic [1:0] MODE_WAIT  = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;

  state_t        state, nextState;
  logic [PW-1:0] prescaler, nextPrescaler;
  logic [7:0]    nextSecLeft;
  logic [1:0]    nextMode;
  logic          nextBusy;
  logic          nextFill, nextDrain, nextWait;
  logic          reqLatched;

  function automatic logic [7:0] durationOf(input logic [1:0] m);
    case (m)
      MODE_FILL:  durationOf = 8'(FILL_SEC);
      MODE_DRAIN: durationOf = 8'(DRAIN_SEC);
      MODE_WAIT:  durationOf = 8'(WAIT_SEC);
      default:    durationOf = 8'd0;
    endcase
  endfunction

  always_comb begin
    case (mode)
      MODE_FILL:  reqLatched = filling;
      MODE_DRAIN: reqLatched = draining;
      MODE_WAIT:  reqLatched = waiting;
      default:    reqLatched = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState     = state;
    nextPrescaler = prescaler;
    nextSecLeft   = secLeft;
    nextMode      = mode;
    nextFill      = 1'b0;
    nextDrain     = 1'b0;
    nextWait      = 1'b0;
    case (state)
      IDLE: begin
        if (draining)     nextMode = MODE_DRAIN;
        else if (filling) nextMode = MODE_FILL;
        else if (waiting) nextMode = MODE_WAIT;
        if (draining || filling || waiting) begin
          nextState     = RUN;
          nextSecLeft   = durationOf(nextMode);
          nextPrescaler = '0;
        end
      end
      RUN: begin
        // Abort outranks a coincident final tick: no pulse once the request is gone.
        if (!reqLatched) begin
          nextState     = IDLE;
          nextMode      = MODE_IDLE;
          nextSecLeft   = 8'd0;
          nextPrescaler = '0;
        end else if (prescaler == TICK_MAX) begin
          nextPrescaler = '0;
          if (secLeft <= 8'd1) begin
            nextSecLeft = 8'd0;
            nextState   = DONE;
            nextFill    = (mode == MODE_FILL);
            nextDrain   = (mode == MODE_DRAIN);
            nextWait    = (mode == MODE_WAIT);
          end else begin
            nextSecLeft = secLeft - 8'd1;
          end
        end else begin
          nextPrescaler = prescaler + PW'(1);
        end
      end
      DONE: nextState = HOLD;
      HOLD: begin
        if (!reqLatched) begin
          nextState = IDLE;
          nextMode  = MODE_IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    nextBusy = (nextState == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler     <= '0;
      secLeft       <= 8'd0;
      mode          <= MODE_IDLE;
      busy          <= 1'b0;
      fillFinished  <= 1'b0;
      drainFinished <= 1'b0;
      waitFinished  <= 1'b0;
    end else begin
      prescaler     <= nextPrescaler;
      secLeft       <= nextSecLeft;
      mode          <= nextMode;
      busy          <= nextBusy;
      fillFinished  <= nextFill;
      drainFinished <= nextDrain;
      waitFinished  <= nextWait;
    end
  end

`ifdef CHAMBER_TIMER_HEX_EN
  // Segment order gfedcba, low = lit.
  function automatic logic [6:0] seg7(input logic [7:0] d);
    case (d)
      8'd0:    seg7 = ~7'b0111111;
      8'd1:    seg7 = ~7'b0000110;
      8'd2:    seg7 = ~7'b1011011;
      8'd3:    seg7 = ~7'b1001111;
      8'd4:    seg7 = ~7'b1100110;
      8'd5:    seg7 = ~7'b1101101;
      8'd6:    seg7 = ~7'b1111101;
      8'd7:    seg7 = ~7'b0000111;
      8'd8:    seg7 = ~7'b1111111;
      8'd9:    seg7 = ~7'b1101111;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [7:0] tensDigit, onesDigit;
  always_comb begin
    tensDigit = (nextSecLeft / 8'd10) % 8'd10;
    onesDigit = nextSecLeft % 8'd10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hexTens <= 7'h7F;
      hexOnes <= 7'h7F;
    end else if (nextMode == MODE_IDLE) begin
      hexTens <= 7'h7F;
      hexOnes <= 7'h7F;
    end else begin
      hexTens <= seg7(tensDigit);
      hexOnes <= seg7(onesDigit);
    end
  end
`endif

endmodule

// File: tb/tb_chamber_timer.sv
// Randomized + directed bench for chamber_timer against an elapsed-cycle reference model.
module tb_chamber_timer;
  localparam int CLK_HZ = 4;
`ifdef CHAMBER_TIMER_HEX_EN
  localparam int FILL = 12;
`else
  localparam int FILL = 3;
`endif
  localparam int DRAIN = 2;
  localparam int WAITS = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic filling = 1'b0, draining = 1'b0, waiting = 1'b0;
  logic fillFinished, drainFinished, waitFinished, busy;
  logic [7:0] secLeft;
  logic [1:0] mode;
`ifdef CHAMBER_TIMER_HEX_EN
  logic [6:0] hexTens, hexOnes;
`endif

  int checks = 0;
  int failures = 0;

  // Reference: phase 0 idle, 1 run, 2 pulse, 3 hold; elapsed counts cycles since start.
  int mPhase = 0;
  int mMode = 0;
  int mElapsed = 0;
  int fillPulses = 0;

  chamber_timer #(.CLK_HZ(CLK_HZ), .FILL_SEC(FILL), .DRAIN_SEC(DRAIN), .WAIT_SEC(WAITS)) dut (
    .clk(clk), .reset(reset),
    .filling(filling), .draining(draining), .waiting(waiting),
    .fillFinished(fillFinished), .drainFinished(drainFinished), .waitFinished(waitFinished),
    .secLeft(secLeft), .mode(mode), .busy(busy)
`ifdef CHAMBER_TIMER_HEX_EN
    , .hexTens(hexTens), .hexOnes(hexOnes)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int durOf(input int m);
    case (m)
      1: return FILL;
      2: return DRAIN;
      3: return WAITS;
      default: return 0;
    endcase
  endfunction

  function automatic logic reqOf(input int m, input logic f, input logic d, input logic w);
    case (m)
      1: return f;
      2: return d;
      3: return w;
      default: return 1'b0;
    endcase
  endfunction

`ifdef CHAMBER_TIMER_HEX_EN
  function automatic logic [6:0] segOf(input int digit);
    logic [6:0] table_[10];
    table_ = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    return ~table_[digit];
  endfunction
`endif

  task automatic modelStep(input logic f, input logic d, input logic w);
    case (mPhase)
      0: begin
        if (d || f || w) begin
          mMode = d ? 2 : (f ? 1 : 3);
          mPhase = 1;
          mElapsed = 0;
        end
      end
      1: begin
        if (!reqOf(mMode, f, d, w)) begin
          mPhase = 0;
          mMode = 0;
        end else begin
          mElapsed++;
          if (mElapsed == durOf(mMode) * CLK_HZ) mPhase = 2;
        end
      end
      2: mPhase = 3;
      default: begin
        if (!reqOf(mMode, f, d, w)) begin
          mPhase = 0;
          mMode = 0;
        end
      end
    endcase
  endtask

  task automatic modelReset();
    mPhase = 0;
    mMode = 0;
    mElapsed = 0;
  endtask

  task automatic checkAll();
    int expSec;
    expSec = (mPhase == 1) ? durOf(mMode) - mElapsed / CLK_HZ : 0;
    checkVal("secLeft", secLeft, expSec);
    checkVal("mode", mode, mMode);
    checkVal("busy", busy, mPhase == 1);
    checkVal("fillFinished", fillFinished, mPhase == 2 && mMode == 1);
    checkVal("drainFinished", drainFinished, mPhase == 2 && mMode == 2);
    checkVal("waitFinished", waitFinished, mPhase == 2 && mMode == 3);
`ifdef CHAMBER_TIMER_HEX_EN
    checkVal("hexTens", hexTens, (mMode == 0) ? 7'h7F : segOf((expSec / 10) % 10));
    checkVal("hexOnes", hexOnes, (mMode == 0) ? 7'h7F : segOf(expSec % 10));
`endif
  endtask

  task automatic step(input logic f, input logic d, input logic w);
    @(negedge clk);
    filling = f;
    draining = d;
    waiting = w;
    @(posedge clk);
    modelStep(f, d, w);
    #1;
    if (fillFinished) fillPulses++;
    checkAll();
  endtask

  task automatic repeatStep(input int n, input logic f, input logic d, input logic w);
    for (int i = 0; i < n; i++) step(f, d, w);
  endtask

  task automatic midCycleReset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    filling = 1'b0;
    draining = 1'b0;
    waiting = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic f, d, w;
    #3;
    checkAll();
    @(negedge clk);
    reset = 1'b1;

    // Fill, then hold request 10 cycles past the pulse: one pulse only.
    fillPulses = 0;
    repeatStep(FILL * CLK_HZ + 1 + 10, 1'b1, 1'b0, 1'b0);
    checkVal("holdMode", mode, 1);
    step(1'b0, 1'b0, 1'b0);
    checkVal("fillPulseCount", fillPulses, 1);
    repeatStep(2, 1'b0, 1'b0, 1'b0);

    // Drain and fill together: drain wins.
    repeatStep(DRAIN * CLK_HZ + 3, 1'b1, 1'b1, 1'b0);
    repeatStep(2, 1'b0, 1'b0, 1'b0);

    // Wait aborted after 2 cycles, then a full interval.
    repeatStep(2, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checkVal("abortSec", secLeft, 0);
    repeatStep(WAITS * CLK_HZ + 3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Abort while another request is high: it restarts from idle.
    repeatStep(3, 1'b1, 1'b0, 1'b0);
    repeatStep(WAITS * CLK_HZ + 3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Reset six cycles into a drain.
    repeatStep(6, 1'b0, 1'b1, 1'b0);
    midCycleReset();
    repeatStep(DRAIN * CLK_HZ + 2, 1'b0, 1'b0, 1'b0);

    // Random levels that change occasionally.
    f = 1'b0;
    d = 1'b0;
    w = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) f = ~f;
      if ($urandom_range(0, 13) == 0) d = ~d;
      if ($urandom_range(0, 7) == 0) w = ~w;
      step(f, d, w);
      if ($urandom_range(0, 999) == 0) midCycleReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
